calc_op_sequencer: RTL
======================

Name: calc_op_sequencer

Overview:
Multi-cycle arithmetic sequencer between the calculator key-handling FSM and a single shared signed fixed-point datapath. It accepts one operation at a time over a valid/ready request channel and runs one of four operations: add/sub in one cycle, mul by iterative shift-add, div by iterative restoring division. It reports overflow and divide-by-zero, then holds the result on a valid/ready response channel.

Parameters:
WIDTH, 25, operand/result width; signed two's complement, Q(WIDTH-FRAC).FRAC format
FRAC, 10, fraction bits (matches calculator FRACTION_BITS)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
abort  in  1  synchronous clear (C key); drops any operation in flight
req_valid  in  1  request valid
req_ready  out  1  high only in IDLE
req_op  in  2  0 add, 1 sub, 2 mul, 3 div
req_a  in  WIDTH  left operand (accumulated result)
req_b  in  WIDTH  right operand (entered argument)
rsp_valid  out  1  result valid; held until rsp_ready
rsp_ready  in  1  consumer accepts result
rsp_result  out  WIDTH  signed fixed-point result
rsp_error  out  2  0 none, 1 overflow, 2 divide-by-zero
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state IDLE; rsp_valid=0, rsp_result=0, rsp_error=0, busy=0; all internal regs cleared. req_ready=1 after reset release.
- Accept: req_valid && req_ready at a rising edge. Latch op, operand signs, magnitudes |a|, |b| (WIDTH bits unsigned; -2^(WIDTH-1) -> 2^(WIDTH-1)) and result sign = sa^sb. Next state EXEC.
- States: IDLE -> EXEC -> {DONE | MUL_IT | DIV_IT}; MUL_IT/DIV_IT -> NORM -> DONE; DONE -> IDLE on rsp_ready.
- EXEC: add/sub computes a±b at WIDTH+1 bits -> DONE. Div with b==0 -> DONE, error 2, result 0. Mul -> MUL_IT (counter=WIDTH). Div -> DIV_IT (counter=WIDTH+FRAC, dividend=|a|<<FRAC).
- MUL_IT: one multiplier bit per cycle, LSB first, into a 2*WIDTH accumulator; WIDTH cycles.
- DIV_IT: one quotient bit per cycle, MSB first, restoring; WIDTH+FRAC cycles.
- NORM: mul magnitude = product>>FRAC (truncate). Div magnitude = quotient. Apply the sign. Both round toward zero.
- Latency, accept edge to rsp_valid high: add/sub 2 cycles; div-by-zero 2; mul WIDTH+3 = 28; div WIDTH+FRAC+3 = 38.
- Overflow (error 1):
  - add/sub: the WIDTH+1-bit sum does not fit WIDTH bits.
  - mul/div: magnitude > 2^(WIDTH-1)-1 when positive, or > 2^(WIDTH-1) when negative.
  - Without the optional feature, the result is the low WIDTH bits of the signed value.
- A zero result is always positive; there is no negative zero.
- DONE: rsp_valid=1. rsp_result and rsp_error are stable until the rsp_ready handshake. rsp_valid drops on the edge where rsp_ready=1. req_ready rises in the following cycle; there is no same-cycle response+accept.
- abort=1: next state IDLE from any state and rsp_valid=0; a pending response is discarded. abort takes priority over accept and response handshakes. rsp_result/rsp_error keep their last values.
- Requests arriving while not IDLE are ignored (req_ready=0); the requester must hold them.
- Async reset mid-operation: immediate IDLE, outputs to reset values.

Optional Feature:
CALC_SEQ_SATURATE_EN
- Defined: on overflow, rsp_result clamps to 2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative); error 1 is still reported.
- Undefined: wrapped result as above; error 1 is reported.
- Latency is identical either way.

Decomposition:
- Package calc_pkg: op codes (OP_ADD/SUB/MUL/DIV), error codes (ERR_NONE/OVF/DIV0), state encoding, FRAC default.
- One natural sub-module: calc_iter_muldiv (unsigned shift-add/restoring core with start/done). The sequencer owns sign handling, overflow and handshakes.

Test Plan:
- Mul: a=1536 (1.5), b=2304 (2.25) -> rsp_result=3456 (3.375), error 0, rsp_valid exactly 28 cycles after accept.
- Div: a=7168 (7.0), b=-2048 (-2.0) -> -3584 (-3.5), error 0, latency 38. Also a=1024, b=3072 -> 341 (toward zero).
- Div-by-zero: a=5120, b=0 -> error 2, result 0, latency 2.
- Add overflow: a=16776192 (16383.0), b=1024 -> error 1. Result -16777216 without the macro; 16777215 with CALC_SEQ_SATURATE_EN.
- Abort: start div, assert abort at cycle 10 -> IDLE next cycle, no rsp_valid. A new add 1024+1024 then returns 2048.
- Backpressure: hold rsp_ready=0 for 20 cycles -> rsp_valid and result stable, req_ready=0 throughout; req_ready=1 one cycle after the handshake.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - op/error/state encodings and default widths for calc_op_sequencer
package calc_pkg;

  localparam int WIDTH_DEFAULT = 25;
  localparam int FRAC_DEFAULT  = 10;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_DIV0 = 2'd2
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXEC   = 3'd1,
    ST_MUL_IT = 3'd2,
    ST_DIV_IT = 3'd3,
    ST_NORM   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/calc_op_sequencer_if.sv
// rtl/calc_op_sequencer_if.sv - request/response handshake bundle for calc_op_sequencer
interface calc_op_sequencer_if #(
  parameter int WIDTH = 25
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [1:0]       rsp_error;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_error
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_error
  );
endinterface

// File: rtl/calc_iter_muldiv.sv
// rtl/calc_iter_muldiv.sv - unsigned iterative shift-add multiplier / restoring divider
module calc_iter_muldiv import calc_pkg::*; #(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int FRAC  = FRAC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      start,
  input  logic                      is_div,
  input  logic [WIDTH-1:0]          a_mag,
  input  logic [WIDTH-1:0]          b_mag,
  output logic                      last,
  output logic [2*WIDTH-FRAC-1:0]   mag
);
  localparam int NDIV = WIDTH + FRAC;
  localparam int PW   = 2 * WIDTH;
  localparam int MW   = PW - FRAC;
  localparam int CW   = $clog2(NDIV + 1);

  logic [CW-1:0]    cnt;
  logic             div_mode;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [NDIV-1:0]  quo;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;

  // Trial subtraction for the next restoring-division quotient bit.
  always_comb begin
    rem_sh   = {rem, quo[NDIV-1]};
    rem_diff = rem_sh - {1'b0, divisor};
  end

  // Load on start, then one mul bit (LSB first) or one quotient bit (MSB first) per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      div_mode <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start) begin
      div_mode <= is_div;
      cnt      <= is_div ? CW'(NDIV) : CW'(WIDTH);
      acc      <= '0;
      mcand    <= {{WIDTH{1'b0}}, b_mag};
      mplier   <= a_mag;
      divisor  <= b_mag;
      rem      <= '0;
      quo      <= {a_mag, {FRAC{1'b0}}};
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (div_mode) begin
        if (!rem_diff[WIDTH]) begin
          rem <= rem_diff[WIDTH-1:0];
          quo <= {quo[NDIV-2:0], 1'b1};
        end else begin
          rem <= rem_sh[WIDTH-1:0];
          quo <= {quo[NDIV-2:0], 1'b0};
        end
      end else begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

  // last marks the cycle whose edge performs the final step; mag is the truncated magnitude.
  assign last = (cnt == CW'(1));
  assign mag  = div_mode ? MW'(quo) : acc[PW-1:FRAC];

endmodule

// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - fixed-point add/sub/mul/div sequencer; CALC_SEQ_SATURATE_EN clamps on overflow
module calc_op_sequencer import calc_pkg::*; #(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int FRAC  = FRAC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  calc_op_sequencer_if.slave bus,
  output logic              busy
);
  localparam int MW = 2 * WIDTH - FRAC;
  localparam logic [MW-1:0] LIM_POS = {{(MW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [MW-1:0] LIM_NEG = LIM_POS + MW'(1);
`ifdef CALC_SEQ_SATURATE_EN
  localparam logic [WIDTH-1:0] RES_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] RES_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_e           state, state_nxt;
  op_e              op_q;
  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             accept, core_start, core_last;
  logic [MW-1:0]    core_mag;
  logic [WIDTH-1:0] a_val, b_val, add_res, md_res;
  logic [WIDTH:0]   sum;
  logic             add_ovf, md_neg, md_ovf;

  calc_iter_muldiv #(.WIDTH(WIDTH), .FRAC(FRAC)) u_core (
    .clk    (clk),
    .reset  (reset),
    .clear  (abort),
    .start  (core_start),
    .is_div (op_q == OP_DIV),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .last   (core_last),
    .mag    (core_mag)
  );

  assign accept = bus.req_valid && bus.req_ready && !abort;

  // Next-state, handshake and core-start decode; abort overrides everything.
  always_comb begin
    state_nxt     = state;
    core_start    = 1'b0;
    busy          = (state != ST_IDLE);
    bus.req_ready = (state == ST_IDLE);
    case (state)
      ST_IDLE: if (bus.req_valid) state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (op_q == OP_MUL) begin
          state_nxt  = ST_MUL_IT;
          core_start = 1'b1;
        end else if (op_q == OP_DIV && b_mag != '0) begin
          state_nxt  = ST_DIV_IT;
          core_start = 1'b1;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_MUL_IT, ST_DIV_IT: if (core_last) state_nxt = ST_NORM;
      ST_NORM: state_nxt = ST_DONE;
      ST_DONE: if (bus.rsp_valid && bus.rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt  = ST_IDLE;
      core_start = 1'b0;
    end
  end

  // Signed add/sub at WIDTH+1 bits and sign/overflow handling of the mul/div magnitude.
  always_comb begin
    a_val   = sa ? -a_mag : a_mag;
    b_val   = sb ? -b_mag : b_mag;
    if (op_q == OP_SUB) sum = {a_val[WIDTH-1], a_val} - {b_val[WIDTH-1], b_val};
    else                sum = {a_val[WIDTH-1], a_val} + {b_val[WIDTH-1], b_val};
    add_ovf = sum[WIDTH] ^ sum[WIDTH-1];
    md_neg  = sa ^ sb;
    md_ovf  = md_neg ? (core_mag > LIM_NEG) : (core_mag > LIM_POS);
`ifdef CALC_SEQ_SATURATE_EN
    add_res = add_ovf ? (sum[WIDTH] ? RES_MIN : RES_MAX) : sum[WIDTH-1:0];
    md_res  = md_ovf ? (md_neg ? RES_MIN : RES_MAX)
                     : (md_neg ? -core_mag[WIDTH-1:0] : core_mag[WIDTH-1:0]);
`else
    add_res = sum[WIDTH-1:0];
    md_res  = md_neg ? -core_mag[WIDTH-1:0] : core_mag[WIDTH-1:0];
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Capture the accepted request as op, operand signs and magnitudes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q  <= OP_ADD;
      sa    <= 1'b0;
      sb    <= 1'b0;
      a_mag <= '0;
      b_mag <= '0;
    end else if (accept) begin
      op_q  <= op_e'(bus.req_op);
      sa    <= bus.req_a[WIDTH-1];
      sb    <= bus.req_b[WIDTH-1];
      a_mag <= bus.req_a[WIDTH-1] ? -bus.req_a : bus.req_a;
      b_mag <= bus.req_b[WIDTH-1] ? -bus.req_b : bus.req_b;
    end
  end

  // Response registers: result/error load at completion, valid held through DONE until taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_error  <= ERR_NONE;
    end else if (abort) begin
      bus.rsp_valid <= 1'b0;
    end else begin
      if (state == ST_EXEC && (op_q == OP_ADD || op_q == OP_SUB)) begin
        bus.rsp_result <= add_res;
        bus.rsp_error  <= add_ovf ? ERR_OVF : ERR_NONE;
      end
      if (state == ST_EXEC && op_q == OP_DIV && b_mag == '0) begin
        bus.rsp_result <= '0;
        bus.rsp_error  <= ERR_DIV0;
      end
      if (state == ST_NORM) begin
        bus.rsp_result <= md_res;
        bus.rsp_error  <= md_ovf ? ERR_OVF : ERR_NONE;
      end
      bus.rsp_valid <= (state == ST_DONE) && !(bus.rsp_valid && bus.rsp_ready);
    end
  end

endmodule
